// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencing controller for the EX-stage multiply/divide unit.
// Runs one MULT/MULTU/DIV/DIVU at a time. Multiplies wait MUL_CYCLES cycles
// before committing the product. Divides run a 32-step restoring loop and
// then a sign fixup. Results are pulsed out as HI/LO write data with write
// enables, and stall holds back later requesters while the unit is busy.
// Optional build macro MULDIV_DIV0_FAST_EN: a divide by zero skips the
// iteration loop and reaches DONE after three edges instead of 34.
module muldiv_ctrl #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        rd_hilo,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        w_hi,
    output logic        w_lo,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int DATA_W = 32;
    localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DIV_CNT_INIT = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [4:0]        cnt;
    logic              sgn_q;     // signed operation (MULT / DIV)
    logic [DATA_W-1:0] a_q;       // raw operands, kept for sign fixup and div-by-zero
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] dvsr_q;    // divisor magnitude
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    logic              accept;
    logic              div0;
    logic [2*DATA_W-1:0] product;
    logic [2*DATA_W-1:0] fixed;
    logic [DATA_W:0]   rem_sh;
    logic              sub_ok;
    logic [DATA_W-1:0] rem_step;
    logic [DATA_W-1:0] quo_step;

    // Magnitude of a value when treated as signed, otherwise unchanged.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v,
                                              input logic sgn);
        return (sgn && v[DATA_W-1]) ? (~v + 32'd1) : v;
    endfunction

    // Full 64-bit product, signed or unsigned.
    function automatic logic [2*DATA_W-1:0] mul_product(input logic [DATA_W-1:0] x,
                                                        input logic [DATA_W-1:0] y,
                                                        input logic sgn);
        logic signed [2*DATA_W-1:0] sx;
        logic signed [2*DATA_W-1:0] sy;
        logic [2*DATA_W-1:0]        ux;
        logic [2*DATA_W-1:0]        uy;
        sx = {{DATA_W{x[DATA_W-1]}}, x};
        sy = {{DATA_W{y[DATA_W-1]}}, y};
        ux = {{DATA_W{1'b0}}, x};
        uy = {{DATA_W{1'b0}}, y};
        if (sgn)
            return sx * sy;
        return ux * uy;
    endfunction

    // Final {hi, lo} of a divide: div-by-zero override, then signed fixup.
    // The 0x80000000 / -1 case falls out of the negation as a natural wrap.
    function automatic logic [2*DATA_W-1:0] div_fixup(input logic [DATA_W-1:0] quo,
                                                      input logic [DATA_W-1:0] rem,
                                                      input logic [DATA_W-1:0] x,
                                                      input logic [DATA_W-1:0] y,
                                                      input logic sgn);
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] r;
        q = quo;
        r = rem;
        if (y == '0)
            return {x, 32'hFFFF_FFFF};
        if (sgn) begin
            if (x[DATA_W-1] ^ y[DATA_W-1])
                q = ~quo + 32'd1;
            if (x[DATA_W-1])
                r = ~rem + 32'd1;
        end
        return {r, q};
    endfunction

    assign accept = start && !cancel && (state == S_IDLE || state == S_DONE);
    assign div0   = (b_q == '0);

    // Result datapath: product, one restoring step, and the divide fixup.
    always_comb begin
        product  = mul_product(a_q, b_q, sgn_q);
        fixed    = div_fixup(quo_q, rem_q, a_q, b_q, sgn_q);
        rem_sh   = {rem_q, quo_q[DATA_W-1]};
        sub_ok   = (rem_sh >= {1'b0, dvsr_q});
        // When the trial subtract succeeds the true difference is below the
        // divisor, so the low 32 bits of the subtraction are exact.
        rem_step = sub_ok ? (rem_sh[DATA_W-1:0] - dvsr_q) : rem_sh[DATA_W-1:0];
        quo_step = {quo_q[DATA_W-2:0], sub_ok};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Next-state logic; cancel always returns to IDLE.
    always_comb begin
        state_n = state;
        if (cancel) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept)
                        state_n = op[1] ? S_DIV : S_MUL;
                    else
                        state_n = S_IDLE;
                end
                S_MUL: begin
                    if (cnt == '0)
                        state_n = S_DONE;
                end
                S_DIV: begin
`ifdef MULDIV_DIV0_FAST_EN
                    if (div0 || cnt == '0)
                        state_n = S_FIX;
`else
                    if (cnt == '0)
                        state_n = S_FIX;
`endif
                end
                S_FIX: begin
                    state_n = S_DONE;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // Operand latch, iteration registers and committed HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            sgn_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            dvsr_q <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (!cancel) begin
            if (accept) begin
                sgn_q  <= op[0];
                a_q    <= a;
                b_q    <= b;
                dvsr_q <= mag(b, op[0]);
                rem_q  <= '0;
                quo_q  <= mag(a, op[0]);
                cnt    <= op[1] ? DIV_CNT_INIT : MUL_CNT_INIT;
            end else begin
                case (state)
                    S_MUL: begin
                        if (cnt == '0)
                            {hi_q, lo_q} <= product;
                        else
                            cnt <= cnt - 5'd1;
                    end
                    S_DIV: begin
                        rem_q <= rem_step;
                        quo_q <= quo_step;
                        if (cnt != '0)
                            cnt <= cnt - 5'd1;
                    end
                    S_FIX: begin
                        {hi_q, lo_q} <= fixed;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign busy  = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
    assign stall = busy && (start || rd_hilo);
    assign done  = (state == S_DONE);
    assign w_hi  = done;
    assign w_lo  = done;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
